// File: rtl/seg_scan_if.sv
// Display-side bundle of the seven-segment scan controller: datapath inputs and board pin outputs.
// The master modport is the datapath/driver side; the slave modport is the scan controller.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enable;
    logic [3:0]              bright;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   seg_anode;
    logic [6:0]              seg_cathode;
    logic                    seg_dp;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    modport master (
        output enable, bright, digit_en, digits_in, dp_in,
        input  seg_anode, seg_cathode, seg_dp, digit_idx, frame_tick
    );

    modport slave (
        input  enable, bright, digit_en, digits_in, dp_in,
        output seg_anode, seg_cathode, seg_dp, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with brightness PWM, dead time, digit mask and frame tick.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int DIV_WIDTH        = 16,
    parameter int DEAD_CYCLES      = 4,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic         clk,
    input  logic         rst,
    seg_scan_if.slave    bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_WIDTH-1:0]  P_MAX     = '1;
    localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = (SEG_ACTIVE_LOW != 0);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            4'hF:    hex7 = 7'h71;
            default: hex7 = 7'h00;
        endcase
    endfunction

    logic [DIV_WIDTH-1:0]    phase_p0;
    logic [IDX_W-1:0]        idx_p0;
    logic                    wrap_p0;
    logic [4*NUM_DIGITS-1:0] frame_digits;
    logic [NUM_DIGITS-1:0]   frame_dp;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   onehot_p0;
    logic [3:0]              nib_p0;
    logic                    dp_p0;
    logic                    en_p0;
    logic                    blank_p0;
    logic                    lit_p0;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is blank only while every more-significant nibble, itself included, is zero.
    always_comb begin
        logic upper_zero;
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (frame_digits[4*k +: 4] == 4'h0);
            lz_blank[k] = upper_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        nib_p0    = '0;
        dp_p0     = 1'b0;
        en_p0     = 1'b0;
        blank_p0  = 1'b0;
        onehot_p0 = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_p0 == IDX_W'(k)) begin
                nib_p0       = frame_digits[4*k +: 4];
                dp_p0        = frame_dp[k];
                en_p0        = bus.digit_en[k];
                blank_p0     = lz_blank[k];
                onehot_p0[k] = 1'b1;
            end
        end
    end

    // PWM window is the top nibble of the phase; dead time guards the digit handover.
    assign lit_p0 = bus.enable && en_p0
                    && (phase_p0 >= DIV_WIDTH'(DEAD_CYCLES))
                    && (phase_p0[DIV_WIDTH-1 -: 4] <= bus.bright);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_p0        <= '0;
            idx_p0          <= '0;
            wrap_p0         <= 1'b0;
            frame_digits    <= '0;
            frame_dp        <= '0;
            bus.seg_anode   <= ANODE_OFF;
            bus.seg_cathode <= SEG_OFF;
            bus.seg_dp      <= DP_OFF;
            bus.digit_idx   <= '0;
            bus.frame_tick  <= 1'b0;
        end else begin
            // p0: scan counters and frame capture
            phase_p0 <= phase_p0 + DIV_WIDTH'(1);
            if (phase_p0 == P_MAX) begin
                idx_p0 <= (idx_p0 == IDX_MAX) ? '0 : idx_p0 + IDX_W'(1);
            end
            wrap_p0 <= (phase_p0 == P_MAX) && (idx_p0 == IDX_MAX);
            if ((phase_p0 == '0) && (idx_p0 == '0)) begin
                frame_digits <= bus.digits_in;
                frame_dp     <= bus.dp_in;
            end
            // p1: anode and cathode registered together so they switch on the same edge
            bus.seg_anode   <= lit_p0 ? (onehot_p0 ^ ANODE_OFF) : ANODE_OFF;
            bus.seg_cathode <= lit_p0 ? ((blank_p0 ? 7'h00 : hex7(nib_p0)) ^ SEG_OFF) : SEG_OFF;
            bus.seg_dp      <= lit_p0 ? (dp_p0 ^ DP_OFF) : DP_OFF;
            bus.digit_idx   <= idx_p0;
            bus.frame_tick  <= wrap_p0;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: time-indexed behavioural model checked every cycle, plus pinned literal cases.
module tb_seg_scan_ctrl;
    localparam int ND    = 4;
    localparam int DW    = 5;
    localparam int DEAD  = 1;
    localparam int SLOT  = 1 << DW;
    localparam int FRAME = SLOT * ND;
    localparam logic [6:0] HEX_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg_scan_if #(.NUM_DIGITS(ND)) bus();

    seg_scan_ctrl #(
        .NUM_DIGITS(ND), .DIV_WIDTH(DW), .DEAD_CYCLES(DEAD),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: n counts clock edges since reset release; slot and phase follow by plain arithmetic.
    int unsigned n = 0;
    logic [15:0] m_frame = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  exp_anode = 4'hF;
    logic [6:0]  exp_cath = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [1:0]  exp_idx = '0;
    logic        exp_tick = 1'b0;

    task automatic model_step();
        int  p, di, nib;
        bit  lit, blank;
        if (rst) begin
            n = 0; m_frame = '0; m_dp = '0;
            exp_anode = 4'hF; exp_cath = 7'h7F; exp_dp = 1'b1; exp_idx = '0; exp_tick = 1'b0;
        end else begin
            p     = int'(n % SLOT);
            di    = int'((n / SLOT) % ND);
            lit   = bus.enable && bus.digit_en[di] && (p >= DEAD) && ((p >> (DW - 4)) <= int'(bus.bright));
            nib   = int'((m_frame >> (4 * di)) & 16'hF);
            blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            blank = (di >= 1) && ((m_frame >> (4 * di)) == 16'h0);
`endif
            exp_anode = lit ? ~(4'b0001 << di) : 4'hF;
            exp_cath  = lit ? ~(blank ? 7'h00 : HEX_TBL[nib]) : 7'h7F;
            exp_dp    = lit ? ~m_dp[di] : 1'b1;
            exp_idx   = 2'(di);
            exp_tick  = (n != 0) && (n % FRAME == 0);
            if (n % FRAME == 0) begin
                m_frame = bus.digits_in;
                m_dp    = bus.dp_in;
            end
            n++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("anode",   32'(bus.seg_anode),   32'(exp_anode));
        chk("cathode", 32'(bus.seg_cathode), 32'(exp_cath));
        chk("dp",      32'(bus.seg_dp),      32'(exp_dp));
        chk("idx",     32'(bus.digit_idx),   32'(exp_idx));
        chk("tick",    32'(bus.frame_tick),  32'(exp_tick));
    end

    int         cnt [ND];
    logic [6:0] cath_seen [ND];
    logic [3:0] anode_seen [ND];
    int         ticks;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic observe(input int cycles);
        for (int k = 0; k < ND; k++) begin
            cnt[k] = 0; cath_seen[k] = 'x; anode_seen[k] = 'x;
        end
        ticks = 0;
        repeat (cycles) begin
            @(negedge clk);
            for (int k = 0; k < ND; k++) begin
                if (bus.seg_anode[k] == 1'b0) begin
                    cnt[k]++;
                    cath_seen[k]  = bus.seg_cathode;
                    anode_seen[k] = bus.seg_anode;
                end
            end
            if (bus.frame_tick) ticks++;
        end
    endtask

    task automatic wait_mod(input int target);
        int guard = 0;
        do begin
            step();
            guard++;
        end while (((n % FRAME) != target) && (guard < 400));
        if ((n % FRAME) != target) begin
            checks++; errors++;
            $display("FAIL wait_mod: frame position %0d, expected %0d", n % FRAME, target);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_anode"},   32'(bus.seg_anode),   32'h0000000F);
        chk({tag, "_cathode"}, 32'(bus.seg_cathode), 32'h0000007F);
        chk({tag, "_dp"},      32'(bus.seg_dp),      32'h1);
        chk({tag, "_idx"},     32'(bus.digit_idx),   32'h0);
        chk({tag, "_tick"},    32'(bus.frame_tick),  32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r16;
        int off;
        bus.enable = 1'b1; bus.bright = 4'd15; bus.digit_en = 4'hF;
        bus.digits_in = 16'h1234; bus.dp_in = 4'b0000;
        #1 rst = 1'b1;
        #1 check_reset_pins("rst_init");
        repeat (3) step();
        rst = 1'b0;

        // Full-brightness scan of 1234
        step(); step();
        observe(FRAME);
        for (int k = 0; k < ND; k++) chk($sformatf("scan_cnt%0d", k), 32'(cnt[k]), 32'd31);
        chk("scan_an0", 32'(anode_seen[0]), 32'b1110);
        chk("scan_an1", 32'(anode_seen[1]), 32'b1101);
        chk("scan_an2", 32'(anode_seen[2]), 32'b1011);
        chk("scan_an3", 32'(anode_seen[3]), 32'b0111);
        chk("scan_cath0", 32'(cath_seen[0]), 32'h19);
        chk("scan_cath1", 32'(cath_seen[1]), 32'h30);
        chk("scan_ticks", 32'(ticks), 32'd1);

        // Brightness
        step(); bus.bright = 4'd3; step();
        observe(FRAME);
        for (int k = 0; k < ND; k++) chk($sformatf("bright3_cnt%0d", k), 32'(cnt[k]), 32'd7);
        step(); bus.bright = 4'd0; step();
        observe(FRAME);
        for (int k = 0; k < ND; k++) chk($sformatf("bright0_cnt%0d", k), 32'(cnt[k]), 32'd1);

        // Digit mask and global enable
        step(); bus.bright = 4'd15; bus.digit_en = 4'b1011; step();
        observe(FRAME);
        chk("mask_cnt2", 32'(cnt[2]), 32'd0);
        chk("mask_cnt3", 32'(cnt[3]), 32'd31);
        chk("mask_ticks", 32'(ticks), 32'd1);
        step(); bus.digit_en = 4'hF; bus.enable = 1'b0; step();
        observe(2 * FRAME);
        chk("off_cnt", 32'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 32'd0);
        chk("off_ticks", 32'(ticks), 32'd2);
        step(); bus.enable = 1'b1;

        // Frame capture: change inputs during the digit-1 slot
        wait_mod(100); bus.digits_in = 16'h1234;
        wait_mod(40);  bus.digits_in = 16'h5678;
        observe(88);
        chk("cap_old1", 32'(cath_seen[1]), 32'h30);
        chk("cap_old2", 32'(cath_seen[2]), 32'h24);
        chk("cap_old3", 32'(cath_seen[3]), 32'h79);
        observe(FRAME);
        chk("cap_new0", 32'(cath_seen[0]), 32'h00);
        chk("cap_new3", 32'(cath_seen[3]), 32'h12);

        // Leading zeros
        wait_mod(100); bus.digits_in = 16'h0050;
        wait_mod(2);
        observe(FRAME);
        chk("lz_d0", 32'(cath_seen[0]), 32'h40);
        chk("lz_d1", 32'(cath_seen[1]), 32'h12);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("lz_d2", 32'(cath_seen[2]), 32'h7F);
        chk("lz_d3", 32'(cath_seen[3]), 32'h7F);
`else
        chk("lz_d2", 32'(cath_seen[2]), 32'h40);
        chk("lz_d3", 32'(cath_seen[3]), 32'h40);
`endif
        chk("lz_cnt3", 32'(cnt[3]), 32'd31);

        // Reset asserted mid-slot while digit 2 is lit
        bus.digits_in = 16'h1234; bus.dp_in = 4'b0101;
        wait_mod(77);
        #1 rst = 1'b1;
        #1 check_reset_pins("rst_mid");
        step(); step();
        rst = 1'b0;

        // Randomised run against the model
        for (int i = 0; i < 2000; i++) begin
            step();
            if ($urandom_range(0, 99) < 5) begin
                r16 = 16'($urandom);
                bus.digits_in = r16 >> (4 * $urandom_range(0, 4));
                bus.dp_in = 4'($urandom);
            end
            if ($urandom_range(0, 99) < 3) bus.bright = 4'($urandom);
            if ($urandom_range(0, 99) < 2) bus.digit_en = 4'($urandom);
            if ($urandom_range(0, 99) < 1) bus.enable = ($urandom_range(0, 4) != 0);
            if (i == 1000) begin
                off = $urandom_range(0, 3);
                off = (off >= 2) ? off + 2 : off + 1;
                #(off) rst = 1'b1;
                step(); step();
                rst = 1'b0;
            end
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment scan controller that replaces the fixed 4-digit refresh-counter/anode pair.
- Generates the one-hot digit strobe, decodes per-digit hex data to cathodes, and provides brightness PWM, a dead-time ghosting guard, a per-digit enable mask and a frame tick.
- Sits between the datapath result registers and the board display pins.

Parameters:
- NUM_DIGITS, 4, digits scanned (2..8).
- DIV_WIDTH, 16, phase counter width; slot length = 2**DIV_WIDTH clk cycles (>=5).
- DEAD_CYCLES, 4, all-anodes-off cycles at start of each slot (< 2**(DIV_WIDTH-4)).
- ANODE_ACTIVE_LOW, 1, 1 = anode asserted low.
- SEG_ACTIVE_LOW, 1, 1 = cathodes and dp asserted low.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  0 = all anodes inactive; counters keep running.
- bright  in  4  brightness level, 0..15.
- digit_en  in  NUM_DIGITS  per-digit enable mask.
- digits_in  in  4*NUM_DIGITS  hex nibbles; digit k = bits [4k+3:4k], digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- seg_anode  out  NUM_DIGITS  one-hot digit strobe, polarity per ANODE_ACTIVE_LOW.
- seg_cathode  out  7  segments, bit0=a .. bit6=g.
- seg_dp  out  1  decimal point.
- digit_idx  out  max(1,$clog2(NUM_DIGITS))  index of the current slot.
- frame_tick  out  1  one-cycle pulse on scan wrap.

Behaviour:
- Phase counter p increments every clk and wraps 2**DIV_WIDTH-1 -> 0.
- When p == 2**DIV_WIDTH-1, the digit index advances; it wraps NUM_DIGITS-1 -> 0.
- frame_tick is registered and asserts for exactly one cycle, coincident with digit_idx changing NUM_DIGITS-1 -> 0.
- Frame capture: at p==0 with index 0, digits_in and dp_in load into a frame register. All decode uses this frame register, so input changes mid-frame never appear until the next frame.
- Digit k is lit when all of the following hold: enable=1, digit_en[k]=1, p >= DEAD_CYCLES, (p >> (DIV_WIDTH-4)) <= bright.
  - bright=15 gives (2**DIV_WIDTH - DEAD_CYCLES) lit cycles per slot.
  - bright=0 gives the first 1/16 of the slot minus dead time.
- A disabled or unlit digit still consumes its slot, so the refresh rate is constant.
- Hex decode, active-high form:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - If SEG_ACTIVE_LOW=1, cathodes and dp are inverted.
- When no anode is lit, cathodes and dp drive all-inactive.
- Latency: seg_anode, seg_cathode, seg_dp and digit_idx are all registered, one cycle after the counter state that produced them. Anode and cathode change on the same edge, so no cross-digit glitch is possible.
- Reset (async assert, sync release):
  - p=0, index=0, frame register=0.
  - seg_anode all inactive, seg_cathode all inactive, seg_dp inactive, digit_idx=0, frame_tick=0.
  - Reset asserted mid-slot takes effect immediately.
  - After release, the first frame capture occurs at the first p==0.

Optional Feature:
- Macro SEG_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k>=1) is blanked when frame-register nibbles k..NUM_DIGITS-1 are all zero. A blanked digit drives cathodes all-inactive while its anode still strobes normally; seg_dp still follows dp_in. Digit 0 is never blanked.
- Undefined: every enabled digit shows its decoded value.

Test Plan:
Use NUM_DIGITS=4, DIV_WIDTH=5, DEAD_CYCLES=1, both active-low; slot = 32 cycles, frame = 128 cycles.
1. Reset: assert rst mid-slot -> same cycle, seg_anode=4'hF, seg_cathode=7'h7F, seg_dp=1, digit_idx=0, frame_tick=0.
2. Scan: bright=15, digit_en=4'hF, enable=1, digits_in=16'h1234 -> seg_anode cycles 1110, 1101, 1011, 0111; each active 31 of 32 cycles; cathode 7'h19 on digit 0 and 7'h30 on digit 1; frame_tick pulses every 128 cycles.
3. Brightness: bright=3 -> each anode active 7 cycles per slot (p=1..7); bright=0 -> 1 cycle (p=1).
4. Mask/enable: digit_en=4'b1011 -> bit2 of seg_anode never 0, frame_tick period stays 128; enable=0 -> seg_anode=4'hF throughout while frame_tick continues.
5. Frame capture: change digits_in from 16'h1234 to 16'h5678 during digit-1 slot -> display keeps 1234 until the next frame start, then shows 5678.
6. Leading zero: digits_in=16'h0050 -> with macro, digits 3 and 2 show cathode 7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40; without macro, digits 3 and 2 show 7'h40.
